// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the 2-read/1-write integer register file.
// No logic, so there is no latency or backpressure.
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int AW_DEFAULT   = 5;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    typedef logic [AW_DEFAULT-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: x0 forced to zero, optional write-first bypass (REGFILE_BYPASS_EN).
// Latency 1 cycle; no backpressure, output returns 0 while busy or held in reset.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int AW   = AW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            busy,
    input  logic [AW-1:0]   raddr,
    input  logic [XLEN-1:0] rf_data,
    input  logic            wr_en,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] rdata_d;

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rdata_d = rf_data;
        if (wr_en && (waddr == raddr)) begin
            rdata_d = wdata;
        end
        if (busy || (raddr == '0)) begin
            rdata_d = '0;
        end
    end
`else
    // Read-first build: the write-side inputs are intentionally left unused here.
    logic unused_bypass;
    assign unused_bypass = ^{wr_en, waddr, wdata};

    always_comb begin
        rdata_d = rf_data;
        if (busy || (raddr == '0)) begin
            rdata_d = '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/regfile_2r1w.sv
// 32 x XLEN integer register file, 2 sync read ports, 1 write port, x0 = 0, post-reset clear sweep.
// Read/write latency 1 cycle; busy during sweep drops writes and zeroes reads. Bypass: REGFILE_BYPASS_EN.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int AW   = AW_DEFAULT
) (
    input  logic            C,
    input  logic            R,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            busy
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    rf_state_t       state_q;
    rf_state_t       state_d;
    logic [AW-1:0]   idx_q;
    logic [AW-1:0]   idx_d;
    logic            wr_en;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        regs_d  = regs_q;
        wr_en   = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                regs_d[idx_q] = '0;
                // idx parks at the last register rather than wrapping back to x0
                if (idx_q == AW'(NREG - 1)) begin
                    state_d = RF_READY;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            RF_READY: begin
                wr_en = we && (waddr != '0);
                if (wr_en) begin
                    regs_d[waddr] = wdata;
                end
            end
            default: begin
                state_d = RF_CLEAR;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q <= RF_CLEAR;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Storage has no reset; the sweep provides deterministic contents instead.
    always_ff @(posedge C) begin
        if (!R) begin
            regs_q <= regs_d;
        end
    end

    assign busy = R || (state_q == RF_CLEAR);

    regfile_rd_port #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_rd_port1 (
        .clk     (C),
        .rst     (R),
        .busy    (busy),
        .raddr   (raddr1),
        .rf_data (regs_q[raddr1]),
        .wr_en   (wr_en),
        .waddr   (waddr),
        .wdata   (wdata),
        .rdata   (rdata1)
    );

    regfile_rd_port #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_rd_port2 (
        .clk     (C),
        .rst     (R),
        .busy    (busy),
        .raddr   (raddr2),
        .rf_data (regs_q[raddr2]),
        .wr_en   (wr_en),
        .waddr   (waddr),
        .wdata   (wdata),
        .rdata   (rdata2)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w; expectations follow the REGFILE_BYPASS_EN build setting.
module tb_regfile_2r1w;

    logic        C;
    logic        R;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        busy;

    int checks = 0;
    int passed = 0;

    regfile_2r1w dut (
        .C      (C),
        .R      (R),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .busy   (busy)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic step;
        @(posedge C);
        #1;
    endtask

    task automatic test_reset;
        int n;
        R = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        step();
        step();
        checks++;
        if (busy !== 1'b1 || rdata1 !== 32'h0 || rdata2 !== 32'h0)
            $display("FAIL reset_state: busy=%b rdata1=%h rdata2=%h, want busy=1 rdata=0", busy, rdata1, rdata2);
        else passed++;
        R = 1'b0;
        raddr1 = 5'd1; raddr2 = 5'd31;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
            if (busy === 1'b1) begin
                checks++;
                if (rdata1 !== 32'h0 || rdata2 !== 32'h0)
                    $display("FAIL reset_sweep_reads: rdata1=%h rdata2=%h at cycle %0d, want 0", rdata1, rdata2, n);
                else passed++;
            end
        end
        checks++;
        if (n !== 31) $display("FAIL reset_busy_len: busy cycles=%0d, want 31", n);
        else passed++;
        for (int i = 1; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(32 - i);
            step();
            checks++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0)
                $display("FAIL reset_cleared x%0d/x%0d: rdata1=%h rdata2=%h, want 0", i, 32 - i, rdata1, rdata2);
            else passed++;
        end
    endtask

    task automatic test_basic;
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        step();
        we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
        step();
        checks++;
        if (rdata1 !== 32'hDEAD_BEEF || rdata2 !== 32'hDEAD_BEEF)
            $display("FAIL basic_x5: rdata1=%h rdata2=%h, want deadbeef", rdata1, rdata2);
        else passed++;
        we = 1'b1; waddr = 5'd31; wdata = 32'h0000_0001;
        step();
        waddr = 5'd1; wdata = 32'h8000_0000;
        step();
        we = 1'b0; raddr1 = 5'd31; raddr2 = 5'd1;
        step();
        checks++;
        if (rdata1 !== 32'h0000_0001 || rdata2 !== 32'h8000_0000)
            $display("FAIL basic_x31_x1: rdata1=%h rdata2=%h, want 00000001/80000000", rdata1, rdata2);
        else passed++;
    endtask

    task automatic test_x0;
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd5;
        step();
        we = 1'b0;
        step();
        checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'hDEAD_BEEF)
            $display("FAIL x0_write_dropped: rdata1=%h rdata2=%h, want 0/deadbeef", rdata1, rdata2);
        else passed++;
    endtask

    task automatic test_bypass;
        logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h1234_5678;
`else
        exp_same = 32'hA5A5_A5A5;
`endif
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5;
        step();
        wdata = 32'h1234_5678; raddr1 = 5'd7; raddr2 = 5'd7;
        step();
        checks++;
        if (rdata2 !== exp_same || rdata1 !== exp_same)
            $display("FAIL bypass_same_edge: rdata1=%h rdata2=%h, want %h", rdata1, rdata2, exp_same);
        else passed++;
        we = 1'b0;
        step();
        checks++;
        if (rdata2 !== 32'h1234_5678)
            $display("FAIL bypass_after: rdata2=%h, want 12345678", rdata2);
        else passed++;
    endtask

    task automatic test_back_to_back;
        we = 1'b1; waddr = 5'd10; wdata = 32'h0000_000A; raddr1 = 5'd0; raddr2 = 5'd7;
        step();
        for (int i = 11; i < 14; i++) begin
            waddr = 5'(i); wdata = 32'(i); raddr1 = 5'(i - 1);
            step();
            checks++;
            if (rdata1 !== 32'(i - 1))
                $display("FAIL back_to_back x%0d: rdata1=%h, want %h", i - 1, rdata1, 32'(i - 1));
            else passed++;
        end
        we = 1'b0; raddr1 = 5'd13;
        step();
        checks++;
        if (rdata1 !== 32'h0000_000D)
            $display("FAIL back_to_back x13: rdata1=%h, want 0000000d", rdata1);
        else passed++;
    endtask

    task automatic test_sweep_writes;
        int n;
        R = 1'b1; we = 1'b0;
        step();
        R = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'h55; raddr1 = 5'd3; raddr2 = 5'd3;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        we = 1'b0;
        checks++;
        if (n !== 31) $display("FAIL sweep_busy_len: busy cycles=%0d, want 31", n);
        else passed++;
        step();
        checks++;
        if (rdata1 !== 32'h0)
            $display("FAIL sweep_write_ignored: x3=%h, want 0", rdata1);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int n;
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        step();
        we = 1'b0; raddr1 = 5'd9; raddr2 = 5'd9;
        step();
        checks++;
        if (rdata1 !== 32'h99) $display("FAIL mid_x9_written: rdata1=%h, want 00000099", rdata1);
        else passed++;
        R = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1 || rdata1 !== 32'h0 || rdata2 !== 32'h0)
            $display("FAIL mid_reset_state: busy=%b rdata1=%h rdata2=%h", busy, rdata1, rdata2);
        else passed++;
        R = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
            if (busy === 1'b1) begin
                checks++;
                if (rdata1 !== 32'h0 || rdata2 !== 32'h0)
                    $display("FAIL mid_sweep_reads: rdata1=%h rdata2=%h at cycle %0d", rdata1, rdata2, n);
                else passed++;
            end
        end
        checks++;
        if (n !== 31) $display("FAIL mid_busy_len: busy cycles=%0d, want 31", n);
        else passed++;
        step();
        checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0)
            $display("FAIL mid_x9_cleared: rdata1=%h rdata2=%h, want 0", rdata1, rdata2);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_x0();
        test_bypass();
        test_back_to_back();
        test_sweep_writes();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Integer register file for the BLI RISC-V core: 32 x XLEN storage, two synchronous read ports, one write port, with x0 hard-wired to zero. It sits between decode, which reads rs1 and rs2, and writeback, which writes rd. It replaces ad-hoc per-register flops with one block that has defined reset, read latency and forwarding behaviour. After reset, a built-in sweep FSM clears every architectural register, so the contents are deterministic without a wide reset fan-out.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, at least 2)
- AW, 5, address width, equal to log2(NREG)

- C  input  1  clock; all state updates on posedge C
- R  input  1  reset, synchronous, active-high
- we  input  1  write enable
- waddr  input  AW  write register index
- wdata  input  XLEN  write data
- raddr1  input  AW  read port 1 index (rs1)
- raddr2  input  AW  read port 2 index (rs2)
- rdata1  output  XLEN  registered read data, port 1
- rdata2  output  XLEN  registered read data, port 2
- busy  output  1  high while the clear sweep runs; writes are ignored and reads return 0

## Operation
- FSM states: CLEAR and READY.
  - R=1 forces CLEAR, sets idx=1, busy=1, rdata1=rdata2=0.
- CLEAR, each cycle with R=0:
  - write 0 to reg[idx], then idx++.
  - When idx==NREG-1, that register is cleared and the FSM enters READY.
  - External we is ignored.
  - rdata1 and rdata2 load 0.
- READY:
  - If we=1 and waddr!=0, reg[waddr] <= wdata.
  - rdataN <= (raddrN==0) ? 0 : reg[raddrN].
- x0 is never stored; any write to index 0 is dropped silently in every state.
- Both read ports may address the same register, or the write address, in the same cycle. No conflicts and no stalls.
- Arithmetic:
  - idx is AW bits wide and never wraps; the terminal compare is against NREG-1.
  - Indices are full width, so every address is in range.
- R asserted mid-sweep or mid-operation restarts the sweep from idx=1. Register contents are not guaranteed until busy falls.

## Timing
- Read latency is 1 cycle: raddrN sampled at edge k produces rdataN valid after edge k. rdataN holds until the next edge.
- Write latency is 1 cycle: a write at edge k is visible to a read sampled at edge k+1.
- A same-edge read of the register being written depends on REGFILE_BYPASS_EN (see Configuration).
- busy is 1 during R and for NREG-1 cycles after R falls. It goes 0 after the edge that clears reg[NREG-1].
  - The first write accepted is on the edge where busy was sampled 0.
- Reset values: rdata1=0, rdata2=0, busy=1, state=CLEAR, idx=1.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Applies in READY when we=1, waddr!=0 and raddrN==waddr at the same edge.
  - rdataN loads wdata (write-first).
- REGFILE_BYPASS_EN undefined:
  - The same case loads the old reg[waddr] (read-first).
  - The pipeline must then forward externally.
- x0 handling and CLEAR behaviour are identical in both builds.

## Structure
- Package regfile_pkg:
  - XLEN_DEFAULT, NREG_DEFAULT and AW_DEFAULT constants.
  - State enum rf_state_t {RF_CLEAR, RF_READY}.
  - reg_idx_t typedef (AW bits).
- One sub-module, regfile_rd_port, instantiated twice. It holds:
  - the x0 zero check
  - the optional bypass compare and mux
  - the output register with reset to 0
- Storage array, write decode and sweep FSM stay in regfile_2r1w.

## Test plan
- Reset sweep: pulse R for 2 cycles, then release.
  - busy stays 1 for exactly 31 cycles, then 0.
  - Reading x1..x31 afterwards returns 0.
- Basic write/read: write x5=0xDEADBEEF, then read raddr1=5 and raddr2=5 on the next edge. Both rdata ports = 0xDEADBEEF one cycle later.
- x0: write x0=0xFFFFFFFF, then read raddr1=0. rdata1=0.
- Same-edge bypass: we=1, waddr=7, wdata=0x12345678, raddr2=7, with x7 previously 0xA5A5A5A5.
  - rdata2=0x12345678 with REGFILE_BYPASS_EN.
  - rdata2=0xA5A5A5A5 without it.
- Writes during sweep: we=1, waddr=3, wdata=0x55 while busy=1. After busy falls, x3 reads 0.
- Reset mid-run: write x9=0x99 in READY, assert R for 1 cycle, release.
  - busy is high for 31 more cycles.
  - x9 reads 0 afterwards.
  - rdata1 and rdata2 are 0 throughout.
